// File: rtl/distance_tick_gen_if.sv
// -----------------------------------------------------------------------------
// distance_tick_gen_if
// Bundles the speed/run/clear controls and the tick/status outputs of the
// treadmill distance tick generator. Clock and reset stay plain module ports.
//
// Signals:
//   speed      8  belt speed in 0.1 km/h units (master -> slave)
//   run        1  1 = belt running, 0 = paused  (master -> slave)
//   clear      1  synchronous session clear     (master -> slave)
//   dist_tick  1  one-cycle pulse per 10 m      (slave -> master)
//   state      2  00 IDLE, 01 RUN, 10 PAUSED    (slave -> master)
//   moving     1  RUN with a non-zero speed_q   (slave -> master)
//   speed_q    8  speed latched at last sample  (slave -> master)
// -----------------------------------------------------------------------------
interface distance_tick_gen_if;
   logic [7:0] speed;
   logic       run;
   logic       clear;
   logic       dist_tick;
   logic [1:0] state;
   logic       moving;
   logic [7:0] speed_q;

   modport master (
      output speed,
      output run,
      output clear,
      input  dist_tick,
      input  state,
      input  moving,
      input  speed_q
   );

   modport slave (
      input  speed,
      input  run,
      input  clear,
      output dist_tick,
      output state,
      output moving,
      output speed_q
   );
endinterface

// File: rtl/distance_tick_gen.sv
// -----------------------------------------------------------------------------
// distance_tick_gen
// Converts belt speed into one-cycle distance ticks (one per 10 m) for the
// downstream BCD distance counter. A prescaler produces a sample strobe every
// SAMPLE_DIV clocks while running; at each sample the speed is added into a
// phase accumulator and a tick is issued whenever it crosses STEP_THRESHOLD,
// keeping the remainder so fractional distance carries exactly.
//
// Ports:
//   clock    in   system clock, rising edge
//   reset_n  in   asynchronous active-low reset
//   bus      slave modport of distance_tick_gen_if (speed, run, clear in;
//            dist_tick, state, moving, speed_q out)
//
// Build option:
//   SPEED_CLAMP_EN  when defined, the sampled speed is limited to MAX_SPEED
//                   before accumulation and before it is shown on speed_q.
// -----------------------------------------------------------------------------
module distance_tick_gen #(
   parameter int         SAMPLE_DIV     = 50000,
   parameter int         STEP_THRESHOLD = 360000,
   parameter int         ACC_W          = 20,
   parameter logic [7:0] MAX_SPEED      = 8'd200
) (
   input  logic                 clock,
   input  logic                 reset_n,
   distance_tick_gen_if.slave   bus
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_RUN    = 2'b01,
      ST_PAUSED = 2'b10
   } state_t;

   localparam int               PRE_W    = $clog2(SAMPLE_DIV);
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SAMPLE_DIV - 1);
   localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1'b1);
   localparam logic [PRE_W-1:0] PRE_ZERO = {PRE_W{1'b0}};
   localparam logic [ACC_W:0]   THRESH   = (ACC_W + 1)'(STEP_THRESHOLD);
   localparam logic [ACC_W-1:0] ACC_ZERO = {ACC_W{1'b0}};

`ifdef SPEED_CLAMP_EN
   localparam logic CLAMP_ON = 1'b1;
`else
   localparam logic CLAMP_ON = 1'b0;
`endif

   state_t           state_r;
   logic [PRE_W-1:0] presc_r;
   logic [ACC_W-1:0] acc_r;
   logic [7:0]       speed_q_r;
   logic             tick_r;
   logic             moving_r;

   logic [7:0]       speed_eff_s;
   logic [ACC_W:0]   sum_s;
   logic             over_s;
   logic [ACC_W-1:0] acc_next_s;

   // Sample datapath: effective (optionally clamped) speed, widened sum and remainder.
   always_comb begin
      speed_eff_s = bus.speed;
      if (CLAMP_ON && (bus.speed > MAX_SPEED)) begin
         speed_eff_s = MAX_SPEED;
      end else begin
         speed_eff_s = bus.speed;
      end
      // One extra bit so accumulator + speed can never wrap before the compare.
      sum_s  = {1'b0, acc_r} + {{(ACC_W - 7){1'b0}}, speed_eff_s};
      over_s = (sum_s >= THRESH);
      if (over_s) begin
         acc_next_s = ACC_W'(sum_s - THRESH);
      end else begin
         acc_next_s = ACC_W'(sum_s);
      end
   end

   // Run/pause/idle FSM with prescaler, accumulator and registered outputs.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_r   <= ST_IDLE;
         presc_r   <= PRE_ZERO;
         acc_r     <= ACC_ZERO;
         speed_q_r <= 8'd0;
         tick_r    <= 1'b0;
         moving_r  <= 1'b0;
      end else if (bus.clear) begin
         // Clear wins over a coinciding sample edge: no tick is produced.
         state_r   <= ST_IDLE;
         presc_r   <= PRE_ZERO;
         acc_r     <= ACC_ZERO;
         speed_q_r <= 8'd0;
         tick_r    <= 1'b0;
         moving_r  <= 1'b0;
      end else begin
         tick_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (bus.run) begin
                  state_r  <= ST_RUN;
                  moving_r <= (speed_q_r != 8'd0);
               end else begin
                  state_r  <= ST_IDLE;
                  moving_r <= 1'b0;
               end
            end
            ST_RUN: begin
               if (!bus.run) begin
                  // Pausing on a sample boundary skips that sample; the
                  // prescaler keeps its value so it fires right after resume.
                  state_r  <= ST_PAUSED;
                  moving_r <= 1'b0;
               end else if (presc_r == PRE_LAST) begin
                  state_r   <= ST_RUN;
                  presc_r   <= PRE_ZERO;
                  speed_q_r <= speed_eff_s;
                  acc_r     <= acc_next_s;
                  tick_r    <= over_s;
                  moving_r  <= (speed_eff_s != 8'd0);
               end else begin
                  state_r  <= ST_RUN;
                  presc_r  <= presc_r + PRE_ONE;
                  moving_r <= (speed_q_r != 8'd0);
               end
            end
            ST_PAUSED: begin
               if (bus.run) begin
                  state_r  <= ST_RUN;
                  moving_r <= (speed_q_r != 8'd0);
               end else begin
                  state_r  <= ST_PAUSED;
                  moving_r <= 1'b0;
               end
            end
            default: begin
               // Unreachable encoding: recover to a clean idle session.
               state_r   <= ST_IDLE;
               presc_r   <= PRE_ZERO;
               acc_r     <= ACC_ZERO;
               speed_q_r <= 8'd0;
               tick_r    <= 1'b0;
               moving_r  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.dist_tick = tick_r;
   assign bus.state     = state_r;
   assign bus.moving    = moving_r;
   assign bus.speed_q   = speed_q_r;

endmodule
